// File: rtl/bcd_pkg.sv
// Shared BCD nibble constants and per-digit increment/decrement helpers.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d >= BCD_MAX) ? BCD_MIN : d + 4'd1;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] d);
    return (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register with clear/load/step; exposes is_max/is_min
// so the top level can build the carry/borrow chain.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             step,
  input  logic             up,
  output logic [BCD_W-1:0] value,
  output logic             is_max,
  output logic             is_min
);

  always_ff @(posedge clk) begin
    if (clear) begin
      value <= BCD_MIN;
    end else if (load) begin
      value <= load_val;
    end else if (step) begin
      value <= up ? bcd_inc(value) : bcd_dec(value);
    end
  end

  assign is_max = (value == BCD_MAX);
  assign is_min = (value == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, wrap/saturate limits,
// a sticky terminal-value match flag and a load-error pulse.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [4*DIGITS-1:0]   count_to,
  output logic [4*DIGITS-1:0]   count,
  output logic                  rco,
  output logic                  done,
  output logic                  load_err
);

  logic [DIGITS-1:0]   is_max, is_min, step;
  logic [DIGITS:0]     chain;
  logic [4*DIGITS-1:0] load_val, next_count;
  logic                load_bad, at_limit, hold, advance;
  logic [BCD_W-1:0]    nib;

  always_comb begin
    advance  = enable & ~clear & ~load;
    at_limit = up ? (&is_max) : (&is_min);
    // Saturating mode freezes every digit at the limit instead of rolling over.
    hold     = at_limit & ~WRAP;
    chain    = '0;
    chain[0] = 1'b1;
    step     = '0;
    load_val = '0;
    load_bad = 1'b0;
    next_count = '0;
    nib      = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      chain[i+1] = chain[i] & (up ? is_max[i] : is_min[i]);
      step[i]    = advance & ~hold & chain[i];
      nib        = data[4*i +: 4];
      if (nib > BCD_MAX) begin
        load_val[4*i +: 4] = BCD_MIN;
        load_bad           = 1'b1;
      end else begin
        load_val[4*i +: 4] = nib;
      end
      next_count[4*i +: 4] = chain[i] ? (up ? bcd_inc(count[4*i +: 4]) : bcd_dec(count[4*i +: 4]))
                                      : count[4*i +: 4];
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : gen_digit
    bcd_digit u_digit (
      .clk      (clk),
      .clear    (clear),
      .load     (load),
      .load_val (load_val[4*g +: 4]),
      .step     (step[g]),
      .up       (up),
      .value    (count[4*g +: 4]),
      .is_max   (is_max[g]),
      .is_min   (is_min[g])
    );
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rco      <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      rco      <= advance & at_limit;
      load_err <= load & load_bad;
      // Only a real step can set done; a load (even of count_to) clears it.
      done     <= load ? 1'b0 : (done | (advance & ~hold & (next_count == count_to)));
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: three instances (4-digit wrap, 2-digit wrap,
// 2-digit saturate) driven in lockstep and checked against an integer model.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        clear = 1'b0, enable = 1'b0, up = 1'b1, load = 1'b0;
  logic [15:0] data = '0, count_to = '0;
  logic [15:0] count4;
  logic [7:0]  count2w, count2s;
  logic        rco4, done4, lerr4, rco2w, done2w, lerr2w, rco2s, done2s, lerr2s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) u_d4w (
    .clk(clk), .clear(clear), .enable(enable), .up(up), .load(load), .data(data),
    .count_to(count_to), .count(count4), .rco(rco4), .done(done4), .load_err(lerr4));

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) u_d2w (
    .clk(clk), .clear(clear), .enable(enable), .up(up), .load(load), .data(data[7:0]),
    .count_to(count_to[7:0]), .count(count2w), .rco(rco2w), .done(done2w),
    .load_err(lerr2w));

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) u_d2s (
    .clk(clk), .clear(clear), .enable(enable), .up(up), .load(load), .data(data[7:0]),
    .count_to(count_to[7:0]), .count(count2s), .rco(rco2s), .done(done2s),
    .load_err(lerr2s));

  // Model: each counter is a plain integer in 0..10^digits-1.
  int m_n[3];
  bit m_rco[3], m_done[3], m_lerr[3];
  int m_dg[3] = '{4, 2, 2};
  bit m_wrap[3] = '{1'b1, 1'b1, 1'b0};

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r = '0;
    int p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((n / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int maxv = (m_dg[k] == 4) ? 9999 : 99;
      logic [15:0] mask = (m_dg[k] == 4) ? 16'hFFFF : 16'h00FF;
      if (clear) begin
        m_n[k] = 0; m_rco[k] = 0; m_done[k] = 0; m_lerr[k] = 0;
      end else if (load) begin
        int v = 0, p = 1;
        bit bad = 0;
        for (int i = 0; i < m_dg[k]; i++) begin
          int nb = int'(data[4*i +: 4]);
          if (nb > 9) begin bad = 1; nb = 0; end
          v = v + nb * p;
          p = p * 10;
        end
        m_n[k] = v; m_lerr[k] = bad; m_rco[k] = 0; m_done[k] = 0;
      end else if (enable) begin
        bit lim = up ? (m_n[k] == maxv) : (m_n[k] == 0);
        m_rco[k] = lim;
        m_lerr[k] = 0;
        if (!(lim && !m_wrap[k])) begin
          if (up) m_n[k] = (m_n[k] == maxv) ? 0 : m_n[k] + 1;
          else    m_n[k] = (m_n[k] == 0) ? maxv : m_n[k] - 1;
          if ((to_bcd(m_n[k]) & mask) == (count_to & mask)) m_done[k] = 1;
        end
      end else begin
        m_rco[k] = 0; m_lerr[k] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("d4w count", count4, to_bcd(m_n[0]));
    chk("d4w rco", 16'(rco4), 16'(m_rco[0]));
    chk("d4w done", 16'(done4), 16'(m_done[0]));
    chk("d4w load_err", 16'(lerr4), 16'(m_lerr[0]));
    chk("d2w count", 16'(count2w), to_bcd(m_n[1]));
    chk("d2w rco", 16'(rco2w), 16'(m_rco[1]));
    chk("d2w done", 16'(done2w), 16'(m_done[1]));
    chk("d2w load_err", 16'(lerr2w), 16'(m_lerr[1]));
    chk("d2s count", 16'(count2s), to_bcd(m_n[2]));
    chk("d2s rco", 16'(rco2s), 16'(m_rco[2]));
    chk("d2s done", 16'(done2s), 16'(m_done[2]));
    chk("d2s load_err", 16'(lerr2s), 16'(m_lerr[2]));
  endtask

  // Inputs are stable from the previous negedge; outputs are sampled at negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic u,
                       input logic [15:0] d);
    clear = c; load = l; enable = e; up = u; data = d;
  endtask

  typedef struct {
    logic        clr, ld, en, up;
    logic [15:0] data;
    logic [15:0] cnt;
    logic        rco, done, lerr;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic l, input logic e, input logic u,
                              input logic [15:0] d, input logic [15:0] cnt,
                              input logic r, input logic dn, input logic le);
    vec_t v;
    v.clr = c; v.ld = l; v.en = e; v.up = u; v.data = d;
    v.cnt = cnt; v.rco = r; v.done = dn; v.lerr = le;
    return v;
  endfunction

  vec_t tbl[14];
  int rco_cnt;

  initial begin
    tbl[0]  = mk(1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 1, 16'h12A4, 16'h1204, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 1, 16'h0000, 16'h1204, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 1, 16'h0000, 16'h1205, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 16'h0000, 16'h1204, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 1, 16'h0347, 16'h0347, 0, 0, 0);
    tbl[6]  = mk(1, 1, 1, 1, 16'h5555, 16'h0000, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 1, 16'h9999, 16'h9999, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 1, 16'h0000, 16'h0000, 1, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1, 16'h0000, 16'h0001, 0, 1, 0);
    tbl[10] = mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0);
    tbl[11] = mk(0, 0, 1, 0, 16'h0000, 16'h9999, 1, 1, 0);
    tbl[12] = mk(0, 1, 1, 1, 16'h0001, 16'h0001, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 16'h0000, 16'h0001, 0, 0, 0);

    @(negedge clk);
    count_to = 16'h0001;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].clr, tbl[i].ld, tbl[i].en, tbl[i].up, tbl[i].data);
      cycle();
      chk($sformatf("tbl[%0d] count", i), count4, tbl[i].cnt);
      chk($sformatf("tbl[%0d] rco", i), 16'(rco4), 16'(tbl[i].rco));
      chk($sformatf("tbl[%0d] done", i), 16'(done4), 16'(tbl[i].done));
      chk($sformatf("tbl[%0d] load_err", i), 16'(lerr4), 16'(tbl[i].lerr));
    end

    // Full 4-digit up sweep: exactly one rco, on the roll to 0000.
    count_to = 16'hFFFF;
    drive(1, 0, 0, 1, 16'h0000);
    cycle();
    drive(0, 0, 1, 1, 16'h0000);
    rco_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      cycle();
      if (rco4) rco_cnt++;
    end
    chk("sweep rco count", 16'(rco_cnt), 16'd1);
    chk("sweep final count", count4, 16'h0000);
    chk("sweep final rco", 16'(rco4), 16'd1);

    // 2-digit wrap down from 00.
    drive(0, 1, 0, 0, 16'h0000);
    cycle();
    drive(0, 0, 1, 0, 16'h0000);
    cycle();
    chk("d2w underflow count", 16'(count2w), 16'h0099);
    chk("d2w underflow rco", 16'(rco2w), 16'd1);
    cycle();
    chk("d2w after count", 16'(count2w), 16'h0098);
    chk("d2w after rco", 16'(rco2w), 16'd0);

    // 2-digit saturate up from 98.
    drive(0, 1, 0, 1, 16'h0098);
    cycle();
    drive(0, 0, 1, 1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("d2s sat count %0d", i), 16'(count2s), 16'h0099);
      chk($sformatf("d2s sat rco %0d", i), 16'(rco2s), (i == 0) ? 16'd0 : 16'd1);
    end

    // done rises on reaching count_to and stays; load clears it.
    count_to = 16'h0005;
    drive(1, 0, 0, 1, 16'h0000);
    cycle();
    drive(0, 0, 1, 1, 16'h0000);
    for (int i = 1; i <= 7; i++) begin
      cycle();
      chk($sformatf("done step %0d", i), 16'(done4), (i >= 5) ? 16'd1 : 16'd0);
    end
    drive(0, 1, 0, 1, 16'h0000);
    cycle();
    chk("done after load", 16'(done4), 16'd0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) count_to = to_bcd(int'($urandom_range(0, 9999)));
      drive(($urandom % 50) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
            (($urandom % 10) == 0) ? ~up : up, 16'($urandom));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
